switch_code_decoder: RTL and testbench

SWITCH_CODE_DECODER -- requirements
Module: switch_code_decoder

---
 rtl/switch_code_decoder_pkg.sv | 32 +++
 rtl/switch_code_filter.sv | 50 +++++
 rtl/switch_code_decoder.sv | 83 ++++++++
 tb/tb_switch_code_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_code_decoder_pkg.sv
// Shared constants and types for the switch code decoder.
package switch_code_decoder_pkg;

  // Raw switch output codes.
  localparam logic [1:0] CODE_IDLE = 2'h0;
  localparam logic [1:0] CODE_ON   = 2'h1;
  localparam logic [1:0] CODE_ILL  = 2'h2;
  localparam logic [1:0] CODE_OFF  = 2'h3;

  // Width of the saturating dwell counter and of the stability counter.
  localparam int DWELL_W = 3;
  localparam int COUNT_W = 3;

  // Committed decoder state.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_ERROR
  } state_t;

  // Maps a legal code to the state it commits to. The illegal code never
  // reaches this path; it falls into the idle default.
  function automatic state_t code_to_state(input logic [1:0] code);
    case (code)
      CODE_ON:  return ST_ON;
      CODE_OFF: return ST_OFF;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/switch_code_filter.sv
// Candidate/stability tracker: reports when the sample on the current edge
// completes a run of STABLE_CYCLES identical codes.
module switch_code_filter
  import switch_code_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [1:0] code,
  output logic       stable_valid,
  output logic [1:0] stable_code
);

  localparam logic [COUNT_W-1:0] STABLE_CNT = COUNT_W'(STABLE_CYCLES);

  logic [1:0]         cand;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_nxt;

  // Run length including the sample arriving on this edge, saturating at max.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count_nxt = COUNT_W'(1);
    if (code == cand) begin
      count_nxt = (count == '1) ? count : count + 1'b1;
    end
  end

  // The run is judged with the current sample included, so a commit lands on
  // the same edge that completes the run.
  assign stable_valid = (count_nxt >= STABLE_CNT);
  assign stable_code  = code;

  // Candidate and count registers; cleared by reset or by an error exit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || clear) begin
      cand  <= CODE_IDLE;
      count <= '0;
    end else begin
      cand  <= code;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/switch_code_decoder.sv
// Debounced switch code decoder: committed IDLE/ON/OFF/ERROR state with a
// change pulse, sticky error flag and saturating dwell counter. All outputs
// are registered.
module switch_code_decoder
  import switch_code_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         code,
  input  logic               clr_err,
  output logic               state_on,
  output logic               state_valid,
  output logic               change,
  output logic               err,
  output logic [DWELL_W-1:0] dwell
);

  state_t     state;
  state_t     state_nxt;
  logic       err_nxt;
  logic       filt_clear;
  logic       stable_valid;
  logic [1:0] stable_code;

  // Leaving ERROR wipes any run collected while errors were pending; an
  // illegal code on the same edge wins and keeps the decoder in ERROR.
  assign filt_clear = (state == ST_ERROR) && clr_err && (code != CODE_ILL);

  switch_code_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk         (clk),
    .rst         (rst),
    .clear       (filt_clear),
    .code        (code),
    .stable_valid(stable_valid),
    .stable_code (stable_code)
  );

  // Next committed state and error flag: illegal code first, then error
  // recovery, then debounced commits.
  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    if (code == CODE_ILL) begin
      state_nxt = ST_ERROR;
      err_nxt   = 1'b1;
    end else if (state == ST_ERROR) begin
      if (clr_err) begin
        state_nxt = ST_IDLE;
        err_nxt   = 1'b0;
      end
    end else if (stable_valid) begin
      state_nxt = code_to_state(stable_code);
    end
  end

  // State register with registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      state_on    <= 1'b0;
      state_valid <= 1'b0;
      change      <= 1'b0;
      err         <= 1'b0;
      dwell       <= '0;
    end else begin
      state       <= state_nxt;
      err         <= err_nxt;
      state_on    <= (state_nxt == ST_ON);
      state_valid <= (state_nxt == ST_ON) || (state_nxt == ST_OFF);
      change      <= (state_nxt != state);
      if (state_nxt != state) begin
        dwell <= '0;
      end else if (dwell != '1) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_code_decoder.sv
// Self-checking bench: hand-derived vector table for the directed scenarios,
// then randomized stimulus against a run-history reference model.
module tb_switch_code_decoder;

  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic [1:0] code;
  logic       clr_err;
  logic       state_on;
  logic       state_valid;
  logic       change;
  logic       err;
  logic [2:0] dwell;

  switch_code_decoder #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .clr_err    (clr_err),
    .state_on   (state_on),
    .state_valid(state_valid),
    .change     (change),
    .err        (err),
    .dwell      (dwell)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- reference model ----------------
  // Model states as plain names: 0 idle, 1 on, 2 off, 3 error.
  int m_state  = 0;
  int m_err    = 0;
  int m_change = 0;
  int m_dwell  = 0;
  int hist[$];

  function automatic int target_of(input int c);
    if (c == 1) return 1;
    if (c == 3) return 2;
    return 0;
  endfunction

  // True when the last S samples since the last reset/clear are all equal.
  function automatic bit run_complete();
    int n;
    n = hist.size();
    if (n < S) return 1'b0;
    for (int i = n - S; i < n; i++)
      if (hist[i] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input int c, input bit clr);
    int prev;
    if (r) begin
      hist.delete();
      m_state = 0; m_err = 0; m_change = 0; m_dwell = 0;
      return;
    end
    prev = m_state;
    if (c == 2) begin
      hist.push_back(c);
      m_state = 3;
      m_err   = 1;
    end else if (m_state == 3) begin
      if (clr) begin
        hist.delete();
        m_state = 0;
        m_err   = 0;
      end else begin
        hist.push_back(c);
      end
    end else begin
      hist.push_back(c);
      if (run_complete()) m_state = target_of(c);
    end
    if (hist.size() > 16) void'(hist.pop_front());
    m_change = (prev != m_state) ? 1 : 0;
    m_dwell  = m_change ? 0 : ((m_dwell < 7) ? m_dwell + 1 : 7);
  endtask

  // Drive one sample, clock it, update the model, settle past the edge.
  task automatic apply(input bit r, input logic [1:0] c, input bit clr);
    rst = r; code = c; clr_err = clr;
    @(posedge clk);
    model_step(r, int'(c), clr);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      tag;
    bit         r;
    logic [1:0] c;
    bit         clr;
    bit         on;
    bit         valid;
    bit         chg;
    bit         e;
    int         dw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string tag, input bit r, input logic [1:0] c,
                              input bit clr, input bit on, input bit valid,
                              input bit chg, input bit e, input int dw);
    vec_t v;
    v.tag = tag; v.r = r; v.c = c; v.clr = clr;
    v.on = on; v.valid = valid; v.chg = chg; v.e = e; v.dw = dw;
    return v;
  endfunction

  initial begin
    rst = 1'b1; code = 2'h0; clr_err = 1'b0;

    // Reset state.
    vecs.push_back(mk("reset",      1, 2'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rst_clr",    1, 2'h2, 1, 0, 0, 0, 0, 0));
    // Scenario 1: ON commits after the 2nd sample, dwell climbs and holds.
    vecs.push_back(mk("s1_first",   0, 2'h1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s1_commit",  0, 2'h1, 0, 1, 1, 1, 0, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk("s1_dwell", 0, 2'h1, 0, 1, 1, 0, 0, (i < 7) ? i : 7));
    // Scenario 2: glitch ignored, OFF committed on the 4th sample.
    vecs.push_back(mk("s2_off1",    0, 2'h3, 0, 1, 1, 0, 0, 7));
    vecs.push_back(mk("s2_glitch",  0, 2'h1, 0, 1, 1, 0, 0, 7));
    vecs.push_back(mk("s2_off2",    0, 2'h3, 0, 1, 1, 0, 0, 7));
    vecs.push_back(mk("s2_commit",  0, 2'h3, 0, 0, 1, 1, 0, 0));
    // Scenario 3: illegal code enters ERROR; legal codes are ignored.
    vecs.push_back(mk("s3_ill",     0, 2'h2, 0, 0, 0, 1, 1, 0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk("s3_hold",  0, 2'h3, 0, 0, 0, 0, 1, i));
    // Scenario 4: illegal wins over clr_err, then a legal clear exits.
    vecs.push_back(mk("s4_prio",    0, 2'h2, 1, 0, 0, 0, 1, 6));
    vecs.push_back(mk("s4_clear",   0, 2'h0, 1, 0, 0, 1, 0, 0));
    // Scenario 5: reset mid-filter discards the partial run.
    vecs.push_back(mk("s5_part",    0, 2'h1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s5_rst",     1, 2'h1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s5_after",   0, 2'h1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s5_commit",  0, 2'h1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("s5_hold",    0, 2'h1, 0, 1, 1, 0, 0, 1));
    // Scenario 6: ON back to IDLE.
    vecs.push_back(mk("s6_idle1",   0, 2'h0, 0, 1, 1, 0, 0, 2));
    vecs.push_back(mk("s6_commit",  0, 2'h0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("s6_same",    0, 2'h0, 0, 0, 0, 0, 0, 1));
    // clr_err outside ERROR does nothing.
    vecs.push_back(mk("clr_noerr",  0, 2'h0, 1, 0, 0, 0, 0, 2));

    foreach (vecs[k]) begin
      apply(vecs[k].r, vecs[k].c, vecs[k].clr);
      check({vecs[k].tag, ".state_on"},    int'(state_on),    int'(vecs[k].on));
      check({vecs[k].tag, ".state_valid"}, int'(state_valid), int'(vecs[k].valid));
      check({vecs[k].tag, ".change"},      int'(change),      int'(vecs[k].chg));
      check({vecs[k].tag, ".err"},         int'(err),         int'(vecs[k].e));
      check({vecs[k].tag, ".dwell"},       int'(dwell),       vecs[k].dw);
    end

    // ---------------- randomized phase against the model ----------------
    begin
      logic [1:0] c;
      bit r, clr;
      c = 2'h0;
      for (int n = 0; n < 600; n++) begin
        r   = ($urandom_range(0, 39) == 0);
        clr = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 19) == 0) c = 2'h2;
        else if ($urandom_range(0, 1) == 0 || c == 2'h2) begin
          case ($urandom_range(0, 2))
            0:       c = 2'h0;
            1:       c = 2'h1;
            default: c = 2'h3;
          endcase
        end
        apply(r, c, clr);
        check("rand.state_on",    int'(state_on),    (m_state == 1) ? 1 : 0);
        check("rand.state_valid", int'(state_valid), (m_state == 1 || m_state == 2) ? 1 : 0);
        check("rand.change",      int'(change),      m_change);
        check("rand.err",         int'(err),         m_err);
        check("rand.dwell",       int'(dwell),       m_dwell);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
